// File: rtl/delay_bit.sv
// Fixed-length single-bit delay line; used to keep sync/DE aligned with the
// pixel pipeline.
module delay_bit #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign q = sr_q[N-1];

endmodule

// File: rtl/vid_dda.sv
// Bresenham-style rate accumulator: each step adds NUM and wraps at DEN,
// pulsing adv on every wrap, so adv fires NUM times per DEN steps.
module vid_dda #(
    parameter int NUM = 1,
    parameter int DEN = 1,
    parameter int W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    output logic adv
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] base;
    logic [W-1:0] sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        base  = clr ? '0 : acc_q;
        sum   = base + W'(NUM);
        adv   = 1'b0;
        acc_d = base;
        if (step) begin
            if (sum >= W'(DEN)) begin
                adv   = 1'b1;
                acc_d = sum - W'(DEN);
            end else begin
                acc_d = sum;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/vid_scanout.sv
// Frame-buffer scan-out: DDA-scaled fetch of packed pixels, unpack to palette
// indices with sync/DE aligned 3 cycles after the timing generator.
module vid_scanout #(
    parameter int SRC_W = 320,
    parameter int SRC_H = 200,
    parameter int DST_W = 640,
    parameter int DST_H = 480,
    parameter int BPP   = 8,
    parameter int FB_DW = 32,
    parameter int FB_AW = 14,
    parameter int FCW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tg_active,
    input  logic             tg_hsync,
    input  logic             tg_vsync,
    input  logic             tg_h_first,
    input  logic             tg_h_last,
    input  logic             tg_v_first,
    input  logic             tg_v_last,
    input  logic [FB_AW-1:0] fb_base,
    output logic [FB_AW-1:0] fb_addr,
    output logic             fb_re,
    input  logic [FB_DW-1:0] fb_rdata,
    output logic [BPP-1:0]   pix_idx,
    output logic             pix_de,
    output logic             pix_hsync,
    output logic             pix_vsync,
    output logic             vs_in_vbl,
    output logic [FCW-1:0]   vs_frame_cnt,
    output logic             vs_eof
);

    localparam int PPW    = FB_DW / BPP;
    localparam int WPL    = SRC_W / PPW;
    localparam int PPW_LG = $clog2(PPW);
    localparam int BPP_LG = $clog2(BPP);
    localparam int ACC_W  = $clog2((DST_W > DST_H) ? DST_W : DST_H) + 1;
    localparam int SX_W   = $clog2(SRC_W + 1);
    localparam int SY_W   = $clog2(SRC_H + 1);

    logic eof, frame_start, synced_cur, act, x_adv, y_adv, fetch;
    logic first_cur, adv_prev_cur;
    logic [SX_W-1:0] sx_cur;
    logic [FB_DW-1:0] word_cur, word_shift;
    logic [PPW_LG+BPP_LG-1:0] shamt;

    logic             synced_q, synced_d;
    logic             first_q, first_d;
    logic             adv_prev_q, adv_prev_d;
    logic [SX_W-1:0]  sx_q, sx_d;
    logic [SY_W-1:0]  sy_q, sy_d;
    logic [FB_AW-1:0] line_addr_q, line_addr_d;
    logic [FB_AW-1:0] base_q, base_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic             fb_re_q, fb_re_d;
    logic             re2_q, re2_d;
    logic [PPW_LG-1:0] sel1_q, sel1_d, sel2_q, sel2_d;
    logic [FB_DW-1:0] word_q, word_d;
    logic [BPP-1:0]   pix_idx_q, pix_idx_d;
    logic             vbl_q, vbl_d;
    logic [FCW-1:0]   cnt_q, cnt_d;
    logic             eof_q, eof_d;

    assign eof         = tg_v_last & tg_h_last;
    assign frame_start = tg_v_first & tg_h_first;
    assign synced_cur  = synced_q | frame_start;
    assign act         = tg_active & synced_cur;

    vid_dda #(.NUM(SRC_W), .DEN(DST_W), .W(ACC_W)) u_x_dda (
        .clk  (clk),
        .rst  (rst),
        .clr  (tg_h_first),
        .step (tg_active),
        .adv  (x_adv)
    );

    vid_dda #(.NUM(SRC_H), .DEN(DST_H), .W(ACC_W)) u_y_dda (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .step (tg_h_first & ~tg_v_first),
        .adv  (y_adv)
    );

    always_comb begin
        synced_d     = synced_cur;
        sx_cur       = tg_h_first ? '0 : sx_q;
        sx_d         = x_adv ? sx_cur + SX_W'(1) : sx_cur;
        adv_prev_cur = tg_h_first ? 1'b0 : adv_prev_q;
        adv_prev_d   = tg_active ? x_adv : adv_prev_cur;
        first_cur    = tg_h_first | first_q;
        first_d      = first_cur & ~tg_active;

        // Y stepping past the last source line repeats that line instead.
        line_addr_d = line_addr_q;
        sy_d        = sy_q;
        if (frame_start) begin
            line_addr_d = base_q;
            sy_d        = '0;
        end else if (y_adv && sy_q != SY_W'(SRC_H - 1)) begin
            line_addr_d = line_addr_q + FB_AW'(WPL);
            sy_d        = sy_q + SY_W'(1);
        end

        fetch     = act & (first_cur | (adv_prev_cur & (sx_cur[PPW_LG-1:0] == '0)));
        fb_re_d   = fetch;
        fb_addr_d = fetch ? line_addr_d + FB_AW'(sx_cur >> PPW_LG) : fb_addr_q;
        sel1_d    = sx_cur[PPW_LG-1:0];

        // Data arrives on the cycle after fb_re; use it directly that cycle.
        sel2_d     = sel1_q;
        re2_d      = fb_re_q;
        word_cur   = re2_q ? fb_rdata : word_q;
        word_d     = word_cur;
        shamt      = {sel2_q, {BPP_LG{1'b0}}};
        word_shift = word_cur >> shamt;
        pix_idx_d  = word_shift[BPP-1:0];

        base_d = eof ? fb_base : base_q;
        vbl_d  = eof ? 1'b1 : (tg_v_first ? 1'b0 : vbl_q);
        cnt_d  = cnt_q + FCW'(eof);
        eof_d  = eof;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced_q    <= 1'b0;
            first_q     <= 1'b0;
            adv_prev_q  <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            line_addr_q <= '0;
            base_q      <= '0;
            fb_addr_q   <= '0;
            fb_re_q     <= 1'b0;
            re2_q       <= 1'b0;
            sel1_q      <= '0;
            sel2_q      <= '0;
            word_q      <= '0;
            pix_idx_q   <= '0;
            vbl_q       <= 1'b0;
            cnt_q       <= '0;
            eof_q       <= 1'b0;
        end else begin
            synced_q    <= synced_d;
            first_q     <= first_d;
            adv_prev_q  <= adv_prev_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            line_addr_q <= line_addr_d;
            base_q      <= base_d;
            fb_addr_q   <= fb_addr_d;
            fb_re_q     <= fb_re_d;
            re2_q       <= re2_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            word_q      <= word_d;
            pix_idx_q   <= pix_idx_d;
            vbl_q       <= vbl_d;
            cnt_q       <= cnt_d;
            eof_q       <= eof_d;
        end
    end

    delay_bit #(.N(3)) u_de_dly (.clk(clk), .rst(rst), .d(act),      .q(pix_de));
    delay_bit #(.N(3)) u_hs_dly (.clk(clk), .rst(rst), .d(tg_hsync), .q(pix_hsync));
    delay_bit #(.N(3)) u_vs_dly (.clk(clk), .rst(rst), .d(tg_vsync), .q(pix_vsync));

    assign fb_addr      = fb_addr_q;
    assign fb_re        = fb_re_q;
    assign pix_idx      = pix_idx_q;
    assign vs_in_vbl    = vbl_q;
    assign vs_frame_cnt = cnt_q;
    assign vs_eof       = eof_q;

endmodule

// File: tb/tb_vid_scanout.sv
// Bench for vid_scanout: two scaled-down instances (2x/2.4x upscale at BPP 8,
// and 1:1 at BPP 4) share one timing generator; a scoreboard checks fetches and pixels.
module tb_vid_scanout;

    localparam int H_ACT = 32, H_TOT = 40, V_ACT = 12, V_TOT = 15;
    localparam int FRAME = H_TOT * V_TOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tg_active = 0, tg_hsync = 0, tg_vsync = 0;
    logic tg_h_first = 0, tg_h_last = 0, tg_v_first = 0, tg_v_last = 0;
    logic [13:0] fb_base = '0;

    logic [13:0] a_addr, b_addr;
    logic        a_re, b_re;
    logic [31:0] a_rdata = '0, b_rdata = '0;
    logic [7:0]  a_pix;
    logic [3:0]  b_pix;
    logic        a_de, a_hs, a_vs, a_vbl, a_eof;
    logic        b_de, b_hs, b_vs, b_vbl, b_eof;
    logic [15:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    vid_scanout #(.SRC_W(16), .SRC_H(5), .DST_W(32), .DST_H(12), .BPP(8),
                  .FB_DW(32), .FB_AW(14), .FCW(16)) u_a (
        .clk(clk), .rst(rst),
        .tg_active(tg_active), .tg_hsync(tg_hsync), .tg_vsync(tg_vsync),
        .tg_h_first(tg_h_first), .tg_h_last(tg_h_last),
        .tg_v_first(tg_v_first), .tg_v_last(tg_v_last),
        .fb_base(fb_base), .fb_addr(a_addr), .fb_re(a_re), .fb_rdata(a_rdata),
        .pix_idx(a_pix), .pix_de(a_de), .pix_hsync(a_hs), .pix_vsync(a_vs),
        .vs_in_vbl(a_vbl), .vs_frame_cnt(a_cnt), .vs_eof(a_eof)
    );

    vid_scanout #(.SRC_W(32), .SRC_H(12), .DST_W(32), .DST_H(12), .BPP(4),
                  .FB_DW(32), .FB_AW(14), .FCW(16)) u_b (
        .clk(clk), .rst(rst),
        .tg_active(tg_active), .tg_hsync(tg_hsync), .tg_vsync(tg_vsync),
        .tg_h_first(tg_h_first), .tg_h_last(tg_h_last),
        .tg_v_first(tg_v_first), .tg_v_last(tg_v_last),
        .fb_base(fb_base), .fb_addr(b_addr), .fb_re(b_re), .fb_rdata(b_rdata),
        .pix_idx(b_pix), .pix_de(b_de), .pix_hsync(b_hs), .pix_vsync(b_vs),
        .vs_in_vbl(b_vbl), .vs_frame_cnt(b_cnt), .vs_eof(b_eof)
    );

    // Frame-buffer word n holds pixel values PPW*n + k, LSB-first.
    function automatic logic [31:0] word_a(input logic [13:0] n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4 * int'(n) + k);
        return w;
    endfunction

    function automatic logic [31:0] word_b(input logic [13:0] n);
        logic [31:0] w;
        for (int k = 0; k < 8; k++) w[4*k +: 4] = 4'(8 * int'(n) + k);
        return w;
    endfunction

    always @(posedge clk) begin
        if (a_re) a_rdata <= word_a(a_addr);
        if (b_re) b_rdata <= word_b(b_addr);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] got);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected output 0x%0h with nothing expected at %0t", name, got, $time);
    endtask

    // Scoreboard queues and reference state
    logic [13:0] qa_addr[$], qb_addr[$];
    logic [7:0]  qa_pix[$];
    logic [3:0]  qb_pix[$];
    logic de_h[4], hs_h[4], vs_h[4];
    logic        m_synced, m_vbl, m_eof_prev;
    logic [15:0] m_cnt;
    logic [13:0] m_base, m_frame_base;
    logic        exp_vbl, exp_eof;
    logic [15:0] exp_cnt;
    int h = 0, v = 0;

    task automatic model_reset();
        qa_addr.delete(); qb_addr.delete(); qa_pix.delete(); qb_pix.delete();
        for (int i = 0; i < 4; i++) begin de_h[i] = 0; hs_h[i] = 0; vs_h[i] = 0; end
        m_synced = 0; m_vbl = 0; m_eof_prev = 0; m_cnt = '0;
        m_base = '0; m_frame_base = '0;
        exp_vbl = 0; exp_eof = 0; exp_cnt = '0;
    endtask

    task automatic drive();
        logic eof, fs;
        int sx, sxp, sy;
        logic [13:0] ad;
        tg_active  = (h < H_ACT) && (v < V_ACT);
        tg_h_first = (h == 0);
        tg_h_last  = (h == H_ACT - 1);
        tg_v_first = (v == 0);
        tg_v_last  = (v == V_ACT - 1);
        tg_hsync   = (h == 34) || (h == 35);
        tg_vsync   = (v == 13);
        eof = tg_v_last & tg_h_last;
        fs  = tg_v_first & tg_h_first;
        for (int i = 3; i > 0; i--) begin
            de_h[i] = de_h[i-1]; hs_h[i] = hs_h[i-1]; vs_h[i] = vs_h[i-1];
        end
        exp_cnt = m_cnt; exp_vbl = m_vbl; exp_eof = m_eof_prev;
        if (rst) begin
            de_h[0] = 0; hs_h[0] = 0; vs_h[0] = 0;
        end else begin
            if (eof) begin
                m_cnt++; m_vbl = 1; m_base = fb_base;
            end else if (tg_v_first) begin
                m_vbl = 0;
            end
            m_eof_prev = eof;
            if (fs) begin m_synced = 1; m_frame_base = m_base; end
            hs_h[0] = tg_hsync; vs_h[0] = tg_vsync;
            de_h[0] = tg_active & m_synced;
            if (tg_active && m_synced) begin
                sx  = h * 16 / 32;
                sxp = (h - 1) * 16 / 32;
                sy  = v * 5 / 12;
                ad  = 14'(int'(m_frame_base) + sy * 4 + sx / 4);
                if (h == 0 || (sx != sxp && sx % 4 == 0)) qa_addr.push_back(ad);
                qa_pix.push_back(8'(4 * int'(ad) + sx % 4));
                ad  = 14'(int'(m_frame_base) + v * 4 + h / 8);
                if (h % 8 == 0) qb_addr.push_back(ad);
                qb_pix.push_back(4'(8 * int'(ad) + h % 8));
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            @(posedge clk); #1;
            h++;
            if (h == H_TOT) begin
                h = 0; v++;
                if (v == V_TOT) v = 0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_addr"}, 32'(a_addr), 0);
        check({tag, "_a_re"},   32'(a_re), 0);
        check({tag, "_a_pix"},  32'(a_pix), 0);
        check({tag, "_a_de"},   32'(a_de), 0);
        check({tag, "_a_sync"}, 32'({a_hs, a_vs}), 0);
        check({tag, "_a_vs"},   32'({a_vbl, a_eof, a_cnt}), 0);
        check({tag, "_b_addr"}, 32'(b_addr), 0);
        check({tag, "_b_re"},   32'(b_re), 0);
        check({tag, "_b_pix"},  32'(b_pix), 0);
        check({tag, "_b_out"},  32'({b_de, b_hs, b_vs, b_vbl, b_eof, b_cnt}), 0);
    endtask

    // Monitor: pop expected values whenever the DUTs present them
    always @(negedge clk) begin
        check("a_pix_de", 32'(a_de), 32'(de_h[3]));
        check("b_pix_de", 32'(b_de), 32'(de_h[3]));
        check("a_hsync", 32'(a_hs), 32'(hs_h[3]));
        check("b_vsync", 32'(b_vs), 32'(vs_h[3]));
        check("a_vsync", 32'(a_vs), 32'(vs_h[3]));
        check("a_eof", 32'(a_eof), 32'(exp_eof));
        check("a_in_vbl", 32'(a_vbl), 32'(exp_vbl));
        check("a_frame_cnt", 32'(a_cnt), 32'(exp_cnt));
        check("b_frame_cnt", 32'(b_cnt), 32'(exp_cnt));
        if (a_re) begin
            if (qa_addr.size() == 0) extra("a_fetch", 32'(a_addr));
            else check("a_fb_addr", 32'(a_addr), 32'(qa_addr.pop_front()));
        end
        if (b_re) begin
            if (qb_addr.size() == 0) extra("b_fetch", 32'(b_addr));
            else check("b_fb_addr", 32'(b_addr), 32'(qb_addr.pop_front()));
        end
        if (a_de) begin
            if (qa_pix.size() == 0) extra("a_pixel", 32'(a_pix));
            else check("a_pix_idx", 32'(a_pix), 32'(qa_pix.pop_front()));
        end
        if (b_de) begin
            if (qb_pix.size() == 0) extra("b_pixel", 32'(b_pix));
            else check("b_pix_idx", 32'(b_pix), 32'(qb_pix.pop_front()));
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;

        run(FRAME);                       // frame 0 from base 0
        run(FRAME / 2);
        fb_base = 14'h2000;               // frame 1 still reads from 0
        run(FRAME / 2);
        run(FRAME / 2);                   // frame 2 reads from 0x2000
        fb_base = 14'h3FF0;
        run(FRAME / 2);
        run(FRAME / 2);                   // frame 3 wraps past 0x3FFF
        fb_base = 14'h0000;
        run(FRAME / 2);

        run(5 * H_TOT + 10);              // mid-line in frame 4
        rst = 1;
        #1;
        check_zero("midline_rst");
        model_reset();
        run(3);
        rst = 0;
        run(FRAME - (5 * H_TOT + 10) - 3);
        run(FRAME);
        run(H_TOT);

        check("a_addr_left", qa_addr.size(), 0);
        check("a_pix_left", qa_pix.size(), 0);
        check("b_addr_left", qb_addr.size(), 0);
        check("b_pix_left", qb_pix.size(), 0);
        check("final_frame_cnt", 32'(a_cnt), 32'(m_cnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
